// File: rtl/mem_access_pkg.sv
// Shared types and exception codes for the memory-access stage.
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] EXC_NONE       = 4'b0000;
  localparam logic [3:0] EXC_MISALIGNED = 4'b0001;
  localparam logic [3:0] EXC_BUS_ERR    = 4'b0010;
  localparam logic [3:0] EXC_TIMEOUT    = 4'b0011;
  localparam logic [3:0] EXC_ILLEGAL    = 4'b0100;
endpackage

// File: rtl/bus_timeout_counter.sv
// Counts BUSY cycles without a bus response; expired fires in the TIMEOUT-th cycle.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  // The increment that would reach TIMEOUT is the expiring one.
  assign expired = enable && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// LEGv8 memory stage: req/ack bus transaction with stall and exception reporting.
// MEM_ALIGN_CHECK_EN enables the MISALIGNED exception; otherwise addresses are forced to doubleword.
module mem_access_unit #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [N-1:0] address,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data,
  output logic         stall,
  output logic         exc_valid,
  output logic [3:0]   exc_cause,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic         bus_err,
  input  logic [N-1:0] bus_rdata
);
  import mem_access_pkg::*;

  state_t       state, state_nxt;
  logic [3:0]   cause_nxt;
  logic         req, expired;
  logic [N-1:0] addr_lat;

  assign req = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_lat = address;
`else
  assign addr_lat = address & ~N'(7);
`endif

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != BUSY),
    .enable  ((state == BUSY) && !bus_ack && !bus_err),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = EXC_NONE;
    case (state)
      IDLE: if (req) begin
        if (mem_read && mem_write) begin
          state_nxt = DONE;
          cause_nxt = EXC_ILLEGAL;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (address[2:0] != 3'b000) begin
          state_nxt = DONE;
          cause_nxt = EXC_MISALIGNED;
        end
`endif
        else state_nxt = BUSY;
      end
      BUSY: begin
        // Error outranks a same-cycle ack.
        if (bus_err) begin
          state_nxt = DONE;
          cause_nxt = EXC_BUS_ERR;
        end else if (bus_ack) begin
          state_nxt = DONE;
        end else if (expired) begin
          state_nxt = DONE;
          cause_nxt = EXC_TIMEOUT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so the core is released the instant reset asserts.
  always_comb begin
    stall = 1'b0;
    if (reset) stall = ((state == IDLE) && req) || (state == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      exc_valid <= 1'b0;
      exc_cause <= EXC_NONE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_req   <= (state_nxt == BUSY);
      exc_valid <= (state_nxt == DONE) && (cause_nxt != EXC_NONE);
      exc_cause <= (state_nxt == DONE) ? cause_nxt : EXC_NONE;
      if ((state == IDLE) && (state_nxt == BUSY)) begin
        bus_addr  <= addr_lat;
        bus_we    <= mem_write;
        bus_wdata <= write_data;
      end
      if ((state == BUSY) && bus_ack && !bus_err && !bus_we)
        read_data <= bus_rdata;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus reset corner sequences.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [63:0] address = '0, write_data = '0;
  logic [63:0] read_data, bus_addr, bus_wdata;
  logic        stall, exc_valid, bus_req, bus_we;
  logic [3:0]  exc_cause;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [63:0] bus_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit #(.N(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [63:0] addr, wdata, rdata;
    int          ackd;      // BUSY cycle in which the response arrives, 0 = never
    logic        err;
    int          req;       // expected bus_req cycles
    logic [3:0]  cause;
    logic [63:0] exp_rdata, exp_addr;
    logic        exp_we;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic rd, logic wr, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] rdata, int ackd, logic err, int req,
                              logic [3:0] cause, logic [63:0] exp_rdata,
                              logic [63:0] exp_addr, logic exp_we);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ackd = ackd; v.err = err; v.req = req; v.cause = cause;
    v.exp_rdata = exp_rdata; v.exp_addr = exp_addr; v.exp_we = exp_we;
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  sc, rc;
    bit  done;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; address = v.addr; write_data = v.wdata;
    #1;
    sc = int'(stall);
    rc = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0;
      if (bus_req) begin
        rc++;
        sc += int'(stall);
        chk(idx, "bus_addr", bus_addr, v.exp_addr);
        chk(idx, "bus_we", 64'(bus_we), 64'(v.exp_we));
        if (v.exp_we) chk(idx, "bus_wdata", bus_wdata, v.wdata);
        if (v.ackd != 0 && rc == v.ackd) begin
          bus_ack = 1'b1; bus_err = v.err; bus_rdata = v.rdata;
        end
      end else begin
        done = 1;
        chk(idx, "done_stall", 64'(stall), 64'd0);
        chk(idx, "exc_valid", 64'(exc_valid), 64'(v.cause != EXC_NONE));
        chk(idx, "exc_cause", 64'(exc_cause), 64'(v.cause));
        chk(idx, "read_data", read_data, v.exp_rdata);
      end
    end
    if (!done) chk(idx, "done_reached", 64'd0, 64'd1);
    chk(idx, "req_cycles", 64'(rc), 64'(v.req));
    chk(idx, "stall_cycles", 64'(sc), 64'(v.req + 1));
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    chk(idx, "idle_stall", 64'(stall), 64'd0);
    chk(idx, "idle_exc_valid", 64'(exc_valid), 64'd0);
    chk(idx, "idle_exc_cause", 64'(exc_cause), 64'd0);
    chk(idx, "idle_bus_req", 64'(bus_req), 64'd0);
  endtask

  initial begin
    vecs[0] = mk(1, 0, 64'h40,  64'h0,    64'hDEADBEEF, 1, 0, 1, EXC_NONE,    64'hDEADBEEF, 64'h40,  0);
    vecs[1] = mk(0, 1, 64'h80,  64'h1234, 64'hAAAA,     3, 0, 3, EXC_NONE,    64'hDEADBEEF, 64'h80,  1);
    vecs[2] = mk(1, 0, 64'h100, 64'h0,    64'hBBBB,     2, 1, 2, EXC_BUS_ERR, 64'hDEADBEEF, 64'h100, 0);
    vecs[3] = mk(1, 1, 64'h48,  64'h0,    64'h0,        0, 0, 0, EXC_ILLEGAL, 64'hDEADBEEF, 64'h0,   0);
    vecs[4] = mk(1, 0, 64'h200, 64'h0,    64'h0,        0, 0, 4, EXC_TIMEOUT, 64'hDEADBEEF, 64'h200, 0);
`ifdef MEM_ALIGN_CHECK_EN
    vecs[5] = mk(1, 0, 64'h43,  64'h0,    64'h5555,     1, 0, 0, EXC_MISALIGNED, 64'hDEADBEEF, 64'h0, 0);
`else
    vecs[5] = mk(1, 0, 64'h43,  64'h0,    64'h5555,     1, 0, 1, EXC_NONE,    64'h5555,     64'h40,  0);
`endif
    vecs[6] = mk(1, 0, 64'h7FF8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, EXC_NONE,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FF8, 0);

    #1;
    chk(-1, "rst_read_data", read_data, 64'd0);
    chk(-1, "rst_bus_req", 64'(bus_req), 64'd0);
    chk(-1, "rst_exc_valid", 64'(exc_valid), 64'd0);
    chk(-1, "rst_exc_cause", 64'(exc_cause), 64'd0);
    chk(-1, "rst_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while BUSY with the load still presented.
    @(negedge clk);
    mem_read = 1'b1; address = 64'h300;
    @(posedge clk); #1;
    chk(7, "busy_bus_req", 64'(bus_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk(7, "rst_async_bus_req", 64'(bus_req), 64'd0);
    chk(7, "rst_async_stall", 64'(stall), 64'd0);
    chk(7, "rst_async_exc_valid", 64'(exc_valid), 64'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 64'h9999;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk(7, "late_ack_bus_req", 64'(bus_req), 64'd0);
    chk(7, "late_ack_stall", 64'(stall), 64'd0);
    chk(7, "late_ack_exc_valid", 64'(exc_valid), 64'd0);
    @(posedge clk); #1;
    chk(7, "late_ack_idle_req", 64'(bus_req), 64'd0);
    chk(7, "late_ack_read_data", read_data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
